// File: rtl/uart_out_linebuf_if.sv
// Character stream bundle for uart_out_linebuf: SimTop-side character
// input, flush request, printer-side drain handshake and status counters.
// The slave modport is the line buffer; the master modport is the
// environment that feeds characters and consumes the drained stream.
interface uart_out_linebuf_if #(
    parameter int DEPTH = 64
);
    logic                     in_valid;
    logic [7:0]               in_ch;
    logic                     flush;
    logic                     out_valid;
    logic [7:0]               out_ch;
    logic                     out_last;
    logic                     out_ready;
    logic [15:0]              drop_cnt;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output in_valid, in_ch, flush, out_ready,
        input  out_valid, out_ch, out_last, drop_cnt, occupancy
    );

    modport slave (
        input  in_valid, in_ch, flush, out_ready,
        output out_valid, out_ch, out_last, drop_cnt, occupancy
    );
endinterface

// File: rtl/uart_out_linebuf.sv
// uart_out_linebuf: line-buffering stage between SimTop's UART character
// strobe and the testbench printer. Characters are accepted every cycle
// (SimTop cannot stall) and held in a circular FIFO until a newline, a full
// buffer, an idle timeout or an explicit flush releases them, so a printed
// line is never interleaved with other simulation messages. Characters that
// arrive while the FIFO is full are dropped and counted (saturating).
// Optional feature: define UART_LINEBUF_CR_STRIP_EN to discard 0x0D on
// input before it reaches the FIFO.
module uart_out_linebuf #(
    parameter int DEPTH       = 64,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_out_linebuf_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
    localparam logic [7:0]    CH_LF    = 8'h0A;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] release_q, release_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [15:0]   drop_q, drop_d;

    logic          ch_ok;
    logic          wr_en;
    logic          drop_en;
    logic          pop;
    logic          idle_hit;
    logic          trigger;
    logic          out_valid;
    logic [7:0]    head_ch;

`ifdef UART_LINEBUF_CR_STRIP_EN
    // Carriage returns vanish before the FIFO: no write, no drop, no timer reset.
    assign ch_ok = (bus.in_ch != 8'h0D);
`else
    assign ch_ok = 1'b1;
`endif

    // Moore output of the drain FSM; the printer sees data only while draining.
    assign out_valid = (state_q == DRAIN);
    assign head_ch   = mem_q[rd_ptr_q];

    // Datapath next-state: write/drop decision, release triggers, idle timer.
    always_comb begin
        pop      = out_valid & bus.out_ready;
        wr_en    = bus.in_valid & ch_ok & (count_q < FULL);
        // A full FIFO drops even when a pop frees a slot in the same cycle.
        drop_en  = bus.in_valid & ch_ok & (count_q == FULL);

        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(wr_en) - CW'(pop);

        idle_hit = (IDLE_CYCLES != 0) && (idle_q == IDLE_MAX);
        trigger  = (wr_en && (bus.in_ch == CH_LF))
                 | (count_d == FULL)
                 | bus.flush
                 | idle_hit;

        // A trigger releases everything stored after this cycle's write/pop;
        // otherwise the released window only shrinks as characters drain.
        if (trigger) begin
            release_d = count_d;
        end else begin
            release_d = release_q - CW'(pop);
        end

        // Timer only runs while something is stored but not yet released.
        if (wr_en || trigger) begin
            idle_d = '0;
        end else if ((count_q > release_q) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IW'(1);
        end else begin
            idle_d = idle_q;
        end

        if (drop_en && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drain FSM next state: draining exactly while released characters remain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (release_d != '0) state_d = DRAIN;
            DRAIN: if (release_d == '0) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ACCUM;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            release_q <= '0;
            idle_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            release_q <= release_d;
            idle_q    <= idle_d;
            drop_q    <= drop_d;
        end
    end

    // Character storage; contents need no reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.in_ch;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_ch    = head_ch;
    assign bus.out_last  = out_valid & ((head_ch == CH_LF) | (release_q == ONE));
    assign bus.drop_cnt  = drop_q;
    assign bus.occupancy = count_q;

endmodule

// File: tb/tb_uart_out_linebuf.sv
// Testbench for uart_out_linebuf: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// queue-based model of the line buffer's release rules.
`timescale 1ns/1ps
module tb_uart_out_linebuf;
    localparam int DEPTH = 64;
    localparam int IDLE  = 16;
`ifdef UART_LINEBUF_CR_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_out_linebuf_if #(.DEPTH(DEPTH)) bif ();

    uart_out_linebuf #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference model: stored characters, released-head count, idle age, drops.
    byte unsigned mq[$];
    int  m_rel  = 0;
    int  m_idle = 0;
    int  m_drop = 0;
    bit  m_pop, m_acc, m_trig;
    int  m_n0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            mq.delete();
            m_rel  = 0;
            m_idle = 0;
            m_drop = 0;
        end else begin
            m_n0  = mq.size();
            m_pop = (m_rel > 0) && bif.out_ready;
            m_acc = 1'b0;
            if (bif.in_valid && !(STRIP && bif.in_ch == 8'h0D)) begin
                if (m_n0 < DEPTH) m_acc = 1'b1;
                else if (m_drop < 65535) m_drop++;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(bif.in_ch);
            m_trig = (m_acc && bif.in_ch == 8'h0A) || (mq.size() == DEPTH) ||
                     bif.flush || (IDLE != 0 && m_idle == IDLE);
            if (m_acc || m_trig) m_idle = 0;
            else if (m_n0 > m_rel && m_idle < IDLE) m_idle++;
            m_rel = m_trig ? mq.size() : (m_rel - int'(m_pop));
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("out_valid", bif.out_valid, (m_rel > 0));
            chk("out_last", bif.out_last, (m_rel > 0) && (mq[0] == 8'h0A || m_rel == 1));
            chk("occupancy", bif.occupancy, mq.size());
            chk("drop_cnt", bif.drop_cnt, m_drop);
            if (m_rel > 0) chk("out_ch", bif.out_ch, mq[0]);
        end
    end

    task automatic drive(input bit v, input byte unsigned c, input bit rdy, input bit fl);
        bif.in_valid  = v;
        bif.in_ch     = c;
        bif.out_ready = rdy;
        bif.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    byte unsigned got_q[$];
    int n_seen, last_idx, wait_n, pv, pr;

    initial begin
        drive(0, 8'h00, 0, 0);
        reset = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b1;
        chk("rst_valid", bif.out_valid, 0);
        chk("rst_last", bif.out_last, 0);
        chk("rst_occ", bif.occupancy, 0);
        chk("rst_drop", bif.drop_cnt, 0);

        // "hi\n" with printer always ready
        drive(1, 8'h68, 1, 0); tick();
        chk("hi_v_h", bif.out_valid, 0);
        drive(1, 8'h69, 1, 0); tick();
        chk("hi_v_i", bif.out_valid, 0);
        drive(1, 8'h0A, 1, 0); tick();
        chk("hi_v_nl", bif.out_valid, 1);
        chk("hi_ch0", bif.out_ch, 8'h68);
        chk("hi_last0", bif.out_last, 0);
        drive(0, 8'h00, 1, 0); tick();
        chk("hi_ch1", bif.out_ch, 8'h69);
        chk("hi_last1", bif.out_last, 0);
        tick();
        chk("hi_ch2", bif.out_ch, 8'h0A);
        chk("hi_last2", bif.out_last, 1);
        tick();
        chk("hi_done_v", bif.out_valid, 0);
        chk("hi_done_occ", bif.occupancy, 0);

        // 70 characters into a 64-deep buffer with printer stalled
        for (int k = 0; k < 70; k++) begin
            drive(1, 8'h61 + 8'(k % 26), 0, 0);
            tick();
            if (k == 62) chk("full_v63", bif.out_valid, 0);
            if (k == 63) begin
                chk("full_v64", bif.out_valid, 1);
                chk("full_occ64", bif.occupancy, 64);
            end
        end
        chk("full_drop", bif.drop_cnt, 6);
        chk("full_occ", bif.occupancy, 64);
        drive(0, 8'h00, 1, 0);
        n_seen = 0; last_idx = -1;
        for (int k = 0; k < 64; k++) begin
            if (bif.out_valid) n_seen++;
            if (bif.out_valid && bif.out_last) last_idx = k;
            tick();
        end
        chk("full_nout", n_seen, 64);
        chk("full_lastidx", last_idx, 63);
        chk("full_empty", bif.occupancy, 0);

        // "ab" then idle until the timeout releases it
        drive(1, 8'h61, 0, 0); tick();
        drive(1, 8'h62, 0, 0); tick();
        drive(0, 8'h00, 0, 0);
        wait_n = 0;
        while (!bif.out_valid && wait_n < 100) begin
            tick();
            wait_n++;
        end
        chk("idle_delay", wait_n, IDLE + 1);
        bif.out_ready = 1'b1;
        chk("idle_ch_a", bif.out_ch, 8'h61);
        chk("idle_last_a", bif.out_last, 0);
        tick();
        chk("idle_ch_b", bif.out_ch, 8'h62);
        chk("idle_last_b", bif.out_last, 1);
        tick();
        chk("idle_done", bif.out_valid, 0);

        // "abc" released by flush, printer ready toggling 1,0,1,0
        drive(1, 8'h61, 0, 0); tick();
        drive(1, 8'h62, 0, 0); tick();
        drive(1, 8'h63, 0, 0); tick();
        chk("fl_hold", bif.out_valid, 0);
        drive(0, 8'h00, 0, 1); tick();
        bif.flush = 1'b0;
        got_q.delete();
        for (int k = 0; k < 20 && got_q.size() < 3; k++) begin
            bif.out_ready = (k % 2 == 0);
            if (bif.out_valid && bif.out_ready) got_q.push_back(bif.out_ch);
            tick();
        end
        chk("fl_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("fl_c0", got_q[0], 8'h61);
            chk("fl_c1", got_q[1], 8'h62);
            chk("fl_c2", got_q[2], 8'h63);
        end
        bif.out_ready = 1'b0;
        tick();
        chk("fl_empty", bif.occupancy, 0);

        // "x\n" released, "yz" written during the drain stays behind
        drive(1, 8'h78, 1, 0); tick();
        drive(1, 8'h0A, 1, 0); tick();
        chk("xz_v", bif.out_valid, 1);
        chk("xz_ch_x", bif.out_ch, 8'h78);
        drive(1, 8'h79, 1, 0); tick();
        chk("xz_ch_nl", bif.out_ch, 8'h0A);
        drive(1, 8'h7A, 1, 0); tick();
        drive(0, 8'h00, 1, 0);
        chk("xz_v_after", bif.out_valid, 0);
        chk("xz_occ", bif.occupancy, 2);
        chk("xz_drop_kept", bif.drop_cnt, 6);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("xz_rst_occ", bif.occupancy, 0);
        chk("xz_rst_drop", bif.drop_cnt, 0);
        chk("xz_rst_v", bif.out_valid, 0);

        // "a\r\n": carriage-return handling
        drive(1, 8'h61, 0, 0); tick();
        drive(1, 8'h0D, 0, 0); tick();
        drive(1, 8'h0A, 0, 0); tick();
        drive(0, 8'h00, 1, 0);
        got_q.delete();
        for (int k = 0; k < 10 && bif.out_valid; k++) begin
            got_q.push_back(bif.out_ch);
            tick();
        end
        if (STRIP) begin
            chk("cr_n", got_q.size(), 2);
            if (got_q.size() == 2) begin
                chk("cr_c0", got_q[0], 8'h61);
                chk("cr_c1", got_q[1], 8'h0A);
            end
        end else begin
            chk("cr_n", got_q.size(), 3);
            if (got_q.size() == 3) begin
                chk("cr_c0", got_q[0], 8'h61);
                chk("cr_c1", got_q[1], 8'h0D);
                chk("cr_c2", got_q[2], 8'h0A);
            end
        end

        // Randomized traffic in phases of differing write and ready rates
        for (int ph = 0; ph < 8; ph++) begin
            pv = (ph % 2 == 0) ? 85 : 30;
            pr = (ph % 4 < 2) ? 20 : 90;
            for (int k = 0; k < 500; k++) begin
                int r;
                r = int'($urandom_range(15));
                bif.in_valid  = ($urandom_range(99) < pv);
                bif.in_ch     = (r == 0) ? 8'h0A : (r == 1) ? 8'h0D : 8'h61 + 8'(r);
                if (ph % 2 == 1 && r < 3) bif.in_ch = 8'h41;
                bif.out_ready = ($urandom_range(99) < pr);
                bif.flush     = ($urandom_range(199) == 0);
                reset         = ($urandom_range(699) != 0);
                tick();
            end
        end

        // Final flush and drain
        reset = 1'b1;
        drive(0, 8'h00, 1, 1); tick();
        bif.flush = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) tick();
        chk("end_empty", bif.occupancy, 0);
        chk("end_v", bif.out_valid, 0);

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
